// File: rtl/r2sdf_butterfly_stage.sv
// Radix-2 SDF decimation-in-frequency butterfly stage: pairs x[n] with x[n+D] through a
// D-entry feedback delay line and emits D sums (twiddle 0) followed by D differences (twiddle n).
module r2sdf_butterfly_stage #(
  parameter int DATA_WIDTH = 16,
  parameter int DELAY_LOG2 = 3
) (
  input  logic                    sys_clk_i,
  input  logic                    sys_rst_i,
  input  logic                    in_valid_i,
  input  logic                    in_sop_i,
  input  logic [DATA_WIDTH-1:0]   in_real_i,
  input  logic [DATA_WIDTH-1:0]   in_imag_i,
  output logic                    out_valid_o,
  output logic                    out_sop_o,
  output logic [DATA_WIDTH:0]     out_real_o,
  output logic [DATA_WIDTH:0]     out_imag_o,
  output logic [DELAY_LOG2-1:0]   out_twiddle_idx_o
);

  localparam int D  = 1 << DELAY_LOG2;
  localparam int CW = DELAY_LOG2 + 1;
  localparam int OW = DATA_WIDTH + 1;

  logic [CW-1:0]         cnt_reg, cnt_next, cnt_eff;
  logic                  primed_reg, primed_next, primed_eff;
  logic                  sop_accept, mid_sop, phase, emit, last_half;
  logic [DELAY_LOG2-1:0] addr;

  logic signed [OW-1:0]  b_re, b_im, a_re, a_im;
  logic signed [OW-1:0]  sum_re, sum_im, diff_re, diff_im;
  logic [2*OW-1:0]       rd_data, wr_data;
  logic [2*OW-1:0]       mem [D];

  logic                  out_valid_reg, out_valid_next;
  logic                  out_sop_reg, out_sop_next;
  logic [OW-1:0]         out_real_reg, out_real_next;
  logic [OW-1:0]         out_imag_reg, out_imag_next;
  logic [DELAY_LOG2-1:0] out_idx_reg, out_idx_next;

  always_comb begin
    sop_accept = in_valid_i && in_sop_i;
    mid_sop    = sop_accept && (cnt_reg != '0);
    cnt_eff    = sop_accept ? '0 : cnt_reg;
    phase      = cnt_eff[CW-1];
    addr       = cnt_eff[DELAY_LOG2-1:0];
    last_half  = phase && (addr == DELAY_LOG2'(D - 1));
    // an abandoned block leaves the delay line holding raw samples, not differences
    primed_eff = primed_reg && !mid_sop;

    rd_data = mem[addr];
    a_re    = rd_data[2*OW-1:OW];
    a_im    = rd_data[OW-1:0];
    b_re    = {in_real_i[DATA_WIDTH-1], in_real_i};
    b_im    = {in_imag_i[DATA_WIDTH-1], in_imag_i};
    sum_re  = a_re + b_re;
    sum_im  = a_im + b_im;
    diff_re = a_re - b_re;
    diff_im = a_im - b_im;
    wr_data = phase ? {diff_re, diff_im} : {b_re, b_im};
    emit    = in_valid_i && (phase || primed_eff);
  end

  always_comb begin
    cnt_next       = cnt_reg;
    primed_next    = primed_reg;
    out_valid_next = emit;
    out_sop_next   = in_valid_i && phase && (addr == '0);
    out_real_next  = out_real_reg;
    out_imag_next  = out_imag_reg;
    out_idx_next   = out_idx_reg;
    if (in_valid_i) begin
      cnt_next = cnt_eff + CW'(1);
      if (mid_sop)
        primed_next = 1'b0;
      if (last_half)
        primed_next = 1'b1;
    end
    if (emit) begin
      out_real_next = phase ? sum_re : a_re;
      out_imag_next = phase ? sum_im : a_im;
      out_idx_next  = phase ? '0 : addr;
    end
  end

  always_ff @(posedge sys_clk_i or posedge sys_rst_i) begin
    if (sys_rst_i) begin
      cnt_reg       <= '0;
      primed_reg    <= 1'b0;
      out_valid_reg <= 1'b0;
      out_sop_reg   <= 1'b0;
      out_real_reg  <= '0;
      out_imag_reg  <= '0;
      out_idx_reg   <= '0;
    end else begin
      cnt_reg       <= cnt_next;
      primed_reg    <= primed_next;
      out_valid_reg <= out_valid_next;
      out_sop_reg   <= out_sop_next;
      out_real_reg  <= out_real_next;
      out_imag_reg  <= out_imag_next;
      out_idx_reg   <= out_idx_next;
    end
  end

  // Delay line: read-before-write at the same address within one cycle.
  generate
    for (genvar gi = 0; gi < D; gi++) begin : g_delay
      always_ff @(posedge sys_clk_i) begin
        if (in_valid_i && (addr == DELAY_LOG2'(gi)))
          mem[gi] <= wr_data;
      end
    end
  endgenerate

  assign out_valid_o       = out_valid_reg;
  assign out_sop_o         = out_sop_reg;
  assign out_real_o        = out_real_reg;
  assign out_imag_o        = out_imag_reg;
  assign out_twiddle_idx_o = out_idx_reg;

endmodule

// File: tb/tb_r2sdf_butterfly_stage.sv
// Scoreboard bench for r2sdf_butterfly_stage (D=8, 16-bit): block-level reference model
// pushes expected outputs per accepted input; each cycle's output is popped and compared.
module tb_r2sdf_butterfly_stage;
  localparam int DW = 16;
  localparam int DL = 3;
  localparam int D  = 1 << DL;

  logic          sys_clk_i = 1'b0;
  logic          sys_rst_i = 1'b1;
  logic          in_valid_i = 1'b0;
  logic          in_sop_i = 1'b0;
  logic [DW-1:0] in_real_i = '0;
  logic [DW-1:0] in_imag_i = '0;
  logic          out_valid_o;
  logic          out_sop_o;
  logic [DW:0]   out_real_o;
  logic [DW:0]   out_imag_o;
  logic [DL-1:0] out_twiddle_idx_o;

  r2sdf_butterfly_stage #(.DATA_WIDTH(DW), .DELAY_LOG2(DL)) dut (
    .sys_clk_i(sys_clk_i), .sys_rst_i(sys_rst_i),
    .in_valid_i(in_valid_i), .in_sop_i(in_sop_i),
    .in_real_i(in_real_i), .in_imag_i(in_imag_i),
    .out_valid_o(out_valid_o), .out_sop_o(out_sop_o),
    .out_real_o(out_real_o), .out_imag_o(out_imag_o),
    .out_twiddle_idx_o(out_twiddle_idx_o)
  );

  always #5 sys_clk_i = ~sys_clk_i;

  typedef struct {
    int re;
    int im;
    int idx;
    bit sop;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass = 0;

  // reference model state
  int   mcnt = 0;
  bit   mprimed = 1'b0;
  int   half_re[D], half_im[D], dif_re[D], dif_im[D];
  int   last_re = 0, last_im = 0, last_idx = 0;

  task automatic check_value(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
  endtask

  function automatic int rnd();
    logic signed [DW-1:0] r;
    r = DW'($urandom);
    return int'(r);
  endfunction

  task automatic model_reset();
    mcnt = 0; mprimed = 1'b0;
    last_re = 0; last_im = 0; last_idx = 0;
    sb.delete();
  endtask

  // drive one cycle (valid, sop, sample), then compare the registered output
  task automatic cyc(input bit v, input bit s, input int re, input int im);
    exp_t e;
    bit   emit;
    int   k;
    emit = 1'b0;
    if (v) begin
      if (s) begin
        if (mcnt != 0) mprimed = 1'b0;
        mcnt = 0;
      end
      if (mcnt < D) begin
        if (mprimed) begin
          e = '{dif_re[mcnt], dif_im[mcnt], mcnt, 1'b0};
          sb.push_back(e);
          emit = 1'b1;
        end
        half_re[mcnt] = re; half_im[mcnt] = im;
      end else begin
        k = mcnt - D;
        e = '{half_re[k] + re, half_im[k] + im, 0, (k == 0)};
        sb.push_back(e);
        emit = 1'b1;
        dif_re[k] = half_re[k] - re;
        dif_im[k] = half_im[k] - im;
        if (k == D - 1) mprimed = 1'b1;
      end
      mcnt = (mcnt + 1) % (2 * D);
    end
    in_valid_i = v; in_sop_i = s;
    in_real_i = DW'(re); in_imag_i = DW'(im);
    @(posedge sys_clk_i); #1;
    check_value("valid", out_valid_o, emit);
    if (emit && sb.size() > 0) begin
      e = sb.pop_front();
      if (out_valid_o) begin
        check_value("real", $signed(out_real_o), e.re);
        check_value("imag", $signed(out_imag_o), e.im);
        check_value("idx", out_twiddle_idx_o, e.idx);
        check_value("sop", out_sop_o, e.sop);
      end
      last_re = e.re; last_im = e.im; last_idx = e.idx;
    end else if (!out_valid_o) begin
      check_value("sop_idle", out_sop_o, 0);
      if (!v) begin
        check_value("hold_real", $signed(out_real_o), last_re);
        check_value("hold_imag", $signed(out_imag_o), last_im);
        check_value("hold_idx", out_twiddle_idx_o, last_idx);
      end
    end
    $display("cyc v=%0b sop=%0b in=%0d,%0d -> ov=%0b osop=%0b out=%0d,%0d idx=%0d",
             v, s, re, im, out_valid_o, out_sop_o, $signed(out_real_o),
             $signed(out_imag_o), out_twiddle_idx_o);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_value({tag, "_valid"}, out_valid_o, 0);
    check_value({tag, "_sop"}, out_sop_o, 0);
    check_value({tag, "_real"}, out_real_o, 0);
    check_value({tag, "_imag"}, out_imag_o, 0);
    check_value({tag, "_idx"}, out_twiddle_idx_o, 0);
  endtask

  initial begin
    #1;
    check_reset_outputs("por");
    repeat (2) @(posedge sys_clk_i);
    @(negedge sys_clk_i);
    sys_rst_i = 1'b0;
    model_reset();

    // impulse block, then zero block
    for (int i = 0; i < 2 * D; i++) cyc(1, i == 0, (i == 0) ? 1000 : 0, 0);
    for (int i = 0; i < 2 * D; i++) cyc(1, i == 0, 0, 0);

    // constant 100+50j for two blocks
    for (int i = 0; i < 4 * D; i++) cyc(1, (i % (2 * D)) == 0, 100, 50);

    // extremes: -32768 + -32768 and 32767 - (-32768)
    for (int i = 0; i < 2 * D; i++) begin
      case (i)
        0:       cyc(1, 1, -32768, 32767);
        1:       cyc(1, 0, 32767, -32768);
        D:       cyc(1, 0, -32768, 32767);
        D + 1:   cyc(1, 0, -32768, 32767);
        default: cyc(1, 0, 0, 0);
      endcase
    end
    for (int i = 0; i < 2 * D; i++) cyc(1, i == 0, 0, 0);

    // bubbles on every other cycle over two blocks
    for (int i = 0; i < 8 * D; i++) begin
      if (i % 2 == 1) cyc(0, 0, 0, 0);
      else cyc(1, (i % (4 * D)) == 0, rnd(), rnd());
    end

    // mid-block sop at n=5
    for (int i = 0; i < 5; i++) cyc(1, i == 0, rnd(), rnd());
    for (int i = 0; i < 2 * D; i++) cyc(1, i == 0, rnd(), rnd());
    for (int i = 0; i < 2 * D; i++) cyc(1, i == 0, 0, 0);

    // asynchronous reset in the middle of a block's second half
    for (int i = 0; i < D + 4; i++) cyc(1, i == 0, rnd(), rnd());
    #2 sys_rst_i = 1'b1;
    #1 check_reset_outputs("rst");
    in_valid_i = 1'b0;
    model_reset();
    @(negedge sys_clk_i);
    sys_rst_i = 1'b0;
    for (int i = 0; i < 2 * D; i++) cyc(1, i == 0, rnd(), rnd());
    for (int i = 0; i < 2 * D; i++) cyc(1, i == 0, 0, 0);
    cyc(0, 0, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
